// File: rtl/drp_port_arbiter_if.sv
// Requester-side and DRP-side signal bundle for drp_port_arbiter.
// The slave modport is the arbiter; master is the environment (requesters plus the DRP itself).
interface drp_port_arbiter_if #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned D_ADDRESS = 7,
    parameter int unsigned D_IN      = 16,
    parameter int unsigned D_O       = 16
);
    logic [N_REQ-1:0]           req;
    logic [N_REQ-1:0]           we;
    logic [N_REQ-1:0]           lock;
    logic [N_REQ*D_ADDRESS-1:0] addr;
    logic [N_REQ*D_IN-1:0]      wdata;
    logic [N_REQ-1:0]           gnt;
    logic [N_REQ-1:0]           ack;
    logic                       err;
    logic [D_O-1:0]             rdata;
    logic                       busy;
    logic                       drp_den;
    logic                       drp_dwe;
    logic [D_ADDRESS-1:0]       drp_daddr;
    logic [D_IN-1:0]            drp_di;
    logic [D_O-1:0]             drp_do;
    logic                       drp_drdy;

    modport master (
        output req, we, lock, addr, wdata, drp_do, drp_drdy,
        input  gnt, ack, err, rdata, busy, drp_den, drp_dwe, drp_daddr, drp_di
    );

    modport slave (
        input  req, we, lock, addr, wdata, drp_do, drp_drdy,
        output gnt, ack, err, rdata, busy, drp_den, drp_dwe, drp_daddr, drp_di
    );
endinterface

// File: rtl/drp_port_arbiter.sv
// Round-robin arbiter sharing one DCM DRP among N_REQ requesters, one read or write at a time,
// with a drdy timeout and an optional lock that keeps the port for an atomic read-modify-write.
module drp_port_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned D_ADDRESS = 7,
    parameter int unsigned D_IN      = 16,
    parameter int unsigned D_O       = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input logic               dclk_in,
    input logic               reset_n,
    drp_port_arbiter_if.slave bus
);
    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CW = $clog2(TIMEOUT);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                 locked_q, locked_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 err_q, err_d;
    logic [D_O-1:0]       rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 den_q, den_d;
    logic                 dwe_q, dwe_d;
    logic [D_ADDRESS-1:0] daddr_q, daddr_d;
    logic [D_IN-1:0]      di_q, di_d;

    logic [PW-1:0] pick;
    logic          pick_valid;
    logic [PW-1:0] grant_idx;
    logic          grant_go;
    logic          clear_lock;
    int unsigned   idx;

    // First requester at or after rr_ptr, with wrap-around.
    always_comb begin
        pick       = rr_ptr_q;
        pick_valid = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!pick_valid && bus.req[idx[PW-1:0]]) begin
                pick       = idx[PW-1:0];
                pick_valid = 1'b1;
            end
        end
    end

    // A locked owner pre-empts arbitration; a released lock falls through to round-robin.
    always_comb begin
        grant_go   = 1'b0;
        grant_idx  = pick;
        clear_lock = 1'b0;
        if (locked_q) begin
            if (bus.req[owner_q]) begin
                grant_go  = 1'b1;
                grant_idx = owner_q;
            end else if (!bus.lock[owner_q]) begin
                clear_lock = 1'b1;
                grant_go   = pick_valid;
            end
        end else begin
            grant_go = pick_valid;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        locked_d = locked_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = err_q;
        rdata_d  = rdata_q;
        den_d    = den_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        di_d     = di_q;
        case (state_q)
            StIdle: begin
                if (clear_lock) begin
                    locked_d = 1'b0;
                    gnt_d    = '0;
                end
                if (grant_go) begin
                    owner_d            = grant_idx;
                    gnt_d              = '0;
                    gnt_d[grant_idx]   = 1'b1;
                    daddr_d            = bus.addr[grant_idx*D_ADDRESS +: D_ADDRESS];
                    di_d               = bus.wdata[grant_idx*D_IN +: D_IN];
                    dwe_d              = bus.we[grant_idx];
                    we_d               = bus.we[grant_idx];
                    den_d              = 1'b1;
                    cnt_d              = '0;
                    state_d            = StIssue;
                end
            end
            StIssue: begin
                den_d   = 1'b0;
                dwe_d   = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // drdy takes priority over a timeout landing on the same cycle.
                if (bus.drp_drdy) begin
                    if (!we_q) begin
                        rdata_d = bus.drp_do;
                    end
                    err_d          = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    state_d        = StDone;
                end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                    err_d          = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    state_d        = StDone;
                end
            end
            StDone: begin
                err_d    = 1'b0;
                rr_ptr_d = (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                locked_d = bus.lock[owner_q];
                if (!bus.lock[owner_q]) begin
                    gnt_d = '0;
                end
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge dclk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            locked_q <= 1'b0;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            den_q    <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            di_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            locked_q <= locked_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            den_q    <= den_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            di_q     <= di_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.drp_den   = den_q;
    assign bus.drp_dwe   = dwe_q;
    assign bus.drp_daddr = daddr_q;
    assign bus.drp_di    = di_q;
endmodule
